// File: rtl/bus_arb_pkg.sv
// Shared types and the round-robin pick function for the bus arbiter.
// Sized for the largest supported host count; modules narrow the result.
package bus_arb_pkg;

    localparam int unsigned MaxHosts = 8;
    localparam int unsigned MaxIdxW  = 3;

    typedef logic [MaxIdxW-1:0] host_idx_max_t;

    typedef struct packed {
        logic          valid;
        host_idx_max_t idx;
    } rr_pick_t;

    // First requester found scanning ptr, ptr+1, ... with wrap at n_hosts.
    function automatic rr_pick_t rr_pick(input logic [MaxHosts-1:0] req,
                                         input host_idx_max_t       ptr,
                                         input int unsigned         n_hosts);
        rr_pick_t    pick;
        int unsigned cand;
        pick = '0;
        for (int unsigned i = 0; i < MaxHosts; i++) begin
            cand = (32'(ptr) + i) % n_hosts;
            if (i < n_hosts && !pick.valid && req[cand[MaxIdxW-1:0]]) begin
                pick.valid = 1'b1;
                pick.idx   = cand[MaxIdxW-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_owner_fifo.sv
// Circular FIFO remembering which host owns each in-flight request.
// Depth need not be a power of two; push and pop together are legal when full.
module bus_owner_fifo #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !pop_i));
`endif

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one OBI-style device port between NrHosts hosts,
// routing each response back to the host that issued the matching request.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts        = 3,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NrHosts-1:0]                     host_req_i,
    output logic [NrHosts-1:0]                     host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                     host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                     host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
    output logic [NrHosts-1:0]                     host_err_o,
    output logic                                   device_req_o,
    output logic [AddressWidth-1:0]                device_addr_o,
    output logic                                   device_we_o,
    output logic [DataWidth/8-1:0]                 device_be_o,
    output logic [DataWidth-1:0]                   device_wdata_o,
    input  logic                                   device_rvalid_i,
    input  logic [DataWidth-1:0]                   device_rdata_i,
    input  logic                                   device_err_i,
    output logic                                   unexpected_rsp_o
);

    localparam int unsigned HostIdxW = $clog2(NrHosts);
    typedef logic [HostIdxW-1:0] host_idx_t;

    host_idx_t           rr_q, rr_d;
    host_idx_t           win_idx, mux_idx, head_idx;
    rr_pick_t            pick;
    logic [MaxHosts-1:0] req_pad;
    logic                can_issue, issue, pop;
    logic                fifo_full, fifo_empty;
    logic                unexpected_q, unexpected_d;

    always_comb begin
        req_pad                = '0;
        req_pad[NrHosts-1:0]   = host_req_i;
        pick                   = rr_pick(req_pad, host_idx_max_t'(rr_q), NrHosts);
        win_idx                = '0;
        for (int unsigned k = 0; k < NrHosts; k++) begin
            if (pick.idx == host_idx_max_t'(k)) win_idx = host_idx_t'(k);
        end

        // A response this cycle frees a slot, so a full FIFO can still accept.
        can_issue = !fifo_full || device_rvalid_i;
        issue     = rst_ni && can_issue && pick.valid;
        mux_idx   = issue ? win_idx : '0;

        host_gnt_o = '0;
        if (issue) host_gnt_o[win_idx] = 1'b1;

        device_req_o   = issue;
        device_addr_o  = host_addr_i[mux_idx];
        device_we_o    = host_we_i[mux_idx];
        device_be_o    = host_be_i[mux_idx];
        device_wdata_o = host_wdata_i[mux_idx];

        rr_d = rr_q;
        if (issue) rr_d = (win_idx == host_idx_t'(NrHosts - 1)) ? '0 : win_idx + 1'b1;

        pop           = device_rvalid_i && !fifo_empty;
        host_rvalid_o = '0;
        host_err_o    = '0;
        if (pop) begin
            host_rvalid_o[head_idx] = 1'b1;
            host_err_o[head_idx]    = device_err_i;
        end
        host_rdata_o = {NrHosts{device_rdata_i}};

        unexpected_d = unexpected_q || (device_rvalid_i && fifo_empty);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q         <= '0;
            unexpected_q <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            unexpected_q <= unexpected_d;
        end
    end

    assign unexpected_rsp_o = unexpected_q;

    bus_owner_fifo #(
        .Width (HostIdxW),
        .Depth (MaxOutstanding)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (issue),
        .wdata_i (win_idx),
        .pop_i   (pop),
        .rdata_o (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(host_gnt_o));
    a_gnt_has_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (host_gnt_o & ~host_req_i) == '0);
    a_rsp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(device_rvalid_i && fifo_empty))
        else $warning("bus_rr_arbiter: response arrived with no outstanding owner");
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: default instance with a 1-cycle RAM model,
// plus a MaxOutstanding=1 instance driven with a slow device.
module tb_bus_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance
    logic [2:0]        host_req, host_gnt, host_we, host_rvalid, host_err;
    logic [2:0][31:0]  host_addr, host_wdata, host_rdata;
    logic [2:0][3:0]   host_be;
    logic              dev_req, dev_we, dev_rvalid, dev_err, unexpected;
    logic [31:0]       dev_addr, dev_wdata, dev_rdata;
    logic [3:0]        dev_be;

    // MaxOutstanding = 1 instance
    logic [2:0]        m_req, m_gnt, m_we, m_rvalid, m_err;
    logic [2:0][31:0]  m_addr, m_wdata, m_rdata;
    logic [2:0][3:0]   m_be;
    logic              m_dev_req, m_dev_we, m_dev_rvalid, m_dev_err, m_unexpected;
    logic [31:0]       m_dev_addr, m_dev_wdata, m_dev_rdata;
    logic [3:0]        m_dev_be;

    bus_rr_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .device_req_o(dev_req), .device_addr_o(dev_addr), .device_we_o(dev_we),
        .device_be_o(dev_be), .device_wdata_o(dev_wdata),
        .device_rvalid_i(dev_rvalid), .device_rdata_i(dev_rdata), .device_err_i(dev_err),
        .unexpected_rsp_o(unexpected)
    );

    bus_rr_arbiter #(.MaxOutstanding(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(m_req), .host_gnt_o(m_gnt), .host_addr_i(m_addr),
        .host_we_i(m_we), .host_be_i(m_be), .host_wdata_i(m_wdata),
        .host_rvalid_o(m_rvalid), .host_rdata_o(m_rdata), .host_err_o(m_err),
        .device_req_o(m_dev_req), .device_addr_o(m_dev_addr), .device_we_o(m_dev_we),
        .device_be_o(m_dev_be), .device_wdata_o(m_dev_wdata),
        .device_rvalid_i(m_dev_rvalid), .device_rdata_i(m_dev_rdata), .device_err_i(m_dev_err),
        .unexpected_rsp_o(m_unexpected)
    );

    // One-cycle RAM model for the default instance
    logic        ram_en = 1'b0;
    logic        err_on_write = 1'b0;
    logic        pend_v = 1'b0, pend_e = 1'b0;
    logic [31:0] pend_d = '0;

    function automatic logic [31:0] ram_data(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (ram_en) begin
            dev_rvalid = pend_v;
            dev_rdata  = pend_d;
            dev_err    = pend_e;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (ram_en) begin
            pend_v = dev_req;
            pend_d = ram_data(dev_addr);
            pend_e = err_on_write && dev_we;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (host_gnt !== 3'b000 || dev_req !== 1'b0 || host_rvalid !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b req=%b rvalid=%b required 000/0/000", host_gnt, dev_req, host_rvalid);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            sample();
            checks++;
            if (host_gnt !== 3'b000 || dev_req !== 1'b0 || unexpected !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle%0d: gnt=%b req=%b unexp=%b required 000/0/0", c, host_gnt, dev_req, unexpected);
            end
        end
    endtask

    task automatic test_single_read();
        ram_en = 1'b1;
        next_cycle();
        host_req     = 3'b100;
        host_addr[2] = 32'h100;
        sample();
        checks++;
        if (host_gnt !== 3'b100 || dev_req !== 1'b1 || dev_addr !== 32'h100) begin
            errors++;
            $display("FAIL single_grant: gnt=%b req=%b addr=%h required 100/1/00000100", host_gnt, dev_req, dev_addr);
        end
        next_cycle();
        host_req = 3'b000;
        sample();
        checks++;
        if (host_rvalid !== 3'b100) begin
            errors++;
            $display("FAIL single_rvalid: got %b required 100", host_rvalid);
        end
        checks++;
        if (host_rdata[2] !== 32'hDEAD_BEEF || host_err !== 3'b000) begin
            errors++;
            $display("FAIL single_rdata: rdata=%h err=%b required deadbeef/000", host_rdata[2], host_err);
        end
    endtask

    task automatic test_round_robin();
        int          n_gnt [3];
        int          n_rsp [3];
        logic [2:0]  exp_g, exp_rv;
        logic [31:0] exp_a;
        for (int k = 0; k < 3; k++) begin
            n_gnt[k] = 0;
            n_rsp[k] = 0;
        end
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            host_req = (c < 9) ? 3'b111 : 3'b000;
            for (int k = 0; k < 3; k++) host_addr[k] = 32'h1000 * (k + 1) + 4 * n_gnt[k];
            sample();
            exp_g  = (c < 9) ? (3'b001 << (c % 3)) : 3'b000;
            exp_rv = (c > 0) ? (3'b001 << ((c - 1) % 3)) : 3'b000;
            checks++;
            if (host_gnt !== exp_g) begin
                errors++;
                $display("FAIL rr_gnt_c%0d: got %b required %b", c, host_gnt, exp_g);
            end
            if (c < 9) begin
                exp_a = 32'h1000 * (c % 3 + 1) + 4 * n_gnt[c % 3];
                checks++;
                if (dev_addr !== exp_a) begin
                    errors++;
                    $display("FAIL rr_addr_c%0d: got %h required %h", c, dev_addr, exp_a);
                end
                n_gnt[c % 3]++;
            end
            checks++;
            if (host_rvalid !== exp_rv) begin
                errors++;
                $display("FAIL rr_rvalid_c%0d: got %b required %b", c, host_rvalid, exp_rv);
            end
            for (int k = 0; k < 3; k++) begin
                if (host_rvalid[k]) begin
                    exp_a = ram_data(32'h1000 * (k + 1) + 4 * n_rsp[k]);
                    checks++;
                    if (host_rdata[k] !== exp_a) begin
                        errors++;
                        $display("FAIL rr_rdata_h%0d_n%0d: got %h required %h", k, n_rsp[k], host_rdata[k], exp_a);
                    end
                    n_rsp[k]++;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (n_rsp[k] != 3) begin
                errors++;
                $display("FAIL rr_rsp_count_h%0d: got %0d required 3", k, n_rsp[k]);
            end
        end
    endtask

    task automatic test_write_error();
        err_on_write = 1'b1;
        next_cycle();
        host_req      = 3'b010;
        host_we       = 3'b010;
        host_addr[1]  = 32'h200;
        host_wdata[1] = 32'h1234_5678;
        host_be[1]    = 4'b0011;
        sample();
        checks++;
        if (host_gnt !== 3'b010 || dev_we !== 1'b1 || dev_wdata !== 32'h1234_5678 ||
            dev_be !== 4'b0011 || dev_addr !== 32'h200) begin
            errors++;
            $display("FAIL wr_issue: gnt=%b we=%b wdata=%h be=%b addr=%h required 010/1/12345678/0011/00000200",
                     host_gnt, dev_we, dev_wdata, dev_be, dev_addr);
        end
        next_cycle();
        host_req = 3'b000;
        host_we  = 3'b000;
        sample();
        checks++;
        if (host_rvalid !== 3'b010 || host_err !== 3'b010) begin
            errors++;
            $display("FAIL wr_err_rsp: rvalid=%b err=%b required 010/010", host_rvalid, host_err);
        end
        err_on_write = 1'b0;
        next_cycle();
        dev_err      = 1'b1;
        host_addr[0] = 32'hABC0;
        sample();
        checks++;
        if (host_err !== 3'b000 || host_rvalid !== 3'b000) begin
            errors++;
            $display("FAIL err_without_rvalid: err=%b rvalid=%b required 000/000", host_err, host_rvalid);
        end
        checks++;
        if (dev_req !== 1'b0 || dev_addr !== 32'hABC0) begin
            errors++;
            $display("FAIL idle_mux_host0: req=%b addr=%h required 0/0000abc0", dev_req, dev_addr);
        end
    endtask

    task automatic test_back_to_back_depth1();
        logic [2:0] g_tab [7];
        logic [2:0] rv_exp;
        g_tab = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b001};
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            m_req        = 3'b011;
            m_dev_rvalid = (c == 3 || c == 6);
            m_dev_rdata  = 32'h0000_0C00 + c;
            sample();
            rv_exp = (c == 3) ? 3'b001 : ((c == 6) ? 3'b010 : 3'b000);
            checks++;
            if (m_gnt !== g_tab[c] || m_dev_req !== (|g_tab[c])) begin
                errors++;
                $display("FAIL d1_gnt_c%0d: gnt=%b req=%b required %b/%b", c, m_gnt, m_dev_req, g_tab[c], |g_tab[c]);
            end
            checks++;
            if (m_rvalid !== rv_exp) begin
                errors++;
                $display("FAIL d1_rvalid_c%0d: got %b required %b", c, m_rvalid, rv_exp);
            end
        end
        next_cycle();
        m_req        = 3'b000;
        m_dev_rvalid = 1'b0;
    endtask

    task automatic test_unexpected();
        ram_en = 1'b0;
        next_cycle();
        dev_rvalid = 1'b1;
        dev_err    = 1'b0;
        dev_rdata  = 32'hBAD0_0001;
        sample();
        checks++;
        if (host_rvalid !== 3'b000 || unexpected !== 1'b0) begin
            errors++;
            $display("FAIL unexp_same_cycle: rvalid=%b unexp=%b required 000/0", host_rvalid, unexpected);
        end
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            dev_rvalid = 1'b0;
            sample();
            checks++;
            if (unexpected !== 1'b1) begin
                errors++;
                $display("FAIL unexp_sticky_c%0d: got %b required 1", c, unexpected);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0] g_tab [3];
        g_tab = '{3'b001, 3'b010, 3'b000};
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            host_req = 3'b011;
            sample();
            checks++;
            if (host_gnt !== g_tab[c] || dev_req !== (|g_tab[c])) begin
                errors++;
                $display("FAIL burst_gnt_c%0d: gnt=%b req=%b required %b/%b", c, host_gnt, dev_req, g_tab[c], |g_tab[c]);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (host_gnt !== 3'b000 || dev_req !== 1'b0 || unexpected !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: gnt=%b req=%b unexp=%b required 000/0/0", host_gnt, dev_req, unexpected);
        end
        next_cycle();
        rst_n    = 1'b1;
        host_req = 3'b000;
        next_cycle();
        dev_rvalid = 1'b1;
        sample();
        checks++;
        if (host_rvalid !== 3'b000) begin
            errors++;
            $display("FAIL stale_rsp_dropped: rvalid=%b required 000", host_rvalid);
        end
        next_cycle();
        dev_rvalid = 1'b0;
        host_req   = 3'b110;
        sample();
        checks++;
        if (unexpected !== 1'b1) begin
            errors++;
            $display("FAIL stale_rsp_flag: got %b required 1", unexpected);
        end
        checks++;
        if (host_gnt !== 3'b010) begin
            errors++;
            $display("FAIL rr_after_reset: got %b required 010", host_gnt);
        end
        next_cycle();
        host_req = 3'b000;
    endtask

    initial begin
        rst_n      = 1'b0;
        host_req   = '0;  host_we = '0;  host_addr = '0;  host_wdata = '0;  host_be = '0;
        dev_rvalid = 1'b0; dev_rdata = '0; dev_err = 1'b0;
        m_req      = '0;  m_we = '0;  m_addr = '0;  m_wdata = '0;  m_be = '0;
        m_dev_rvalid = 1'b0; m_dev_rdata = '0; m_dev_err = 1'b0;

        test_reset();
        test_single_read();
        test_round_robin();
        test_write_error();
        test_back_to_back_depth1();
        test_unexpected();
        test_reset_mid_burst();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
